fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register that feeds the decode-stage control unit. Holds the PC, drives the instruction-memory address, and registers the fetched instruction into IF/ID. Exposes opcode and function_code from the IF/ID register. Applies branch/jump redirects, flushes, stalls, and halt/overflow stops issued by the control unit and the hazard logic.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/pc_target_calc.sv | 38 +++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and decode-side logic.
//   - BUBBLE_INSTR: encoding injected into IF/ID when no real instruction is present
//   - fetch_state_e: fetch-stage run state
//   - opcode constants and instruction field positions
package cpu_pkg;

  // Opcode 0011 is unassigned, so the bubble decodes to all-zero controls. All-zero
  // is the HALT opcode and therefore can never serve as the bubble.
  localparam logic [15:0] BUBBLE_INSTR = 16'h3000;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHalt  = 2'd1,
    StError = 2'd2
  } fetch_state_e;

  // Opcodes (instr[15:12])
  localparam logic [3:0] OP_HALT   = 4'h0;
  localparam logic [3:0] OP_ALU    = 4'h1;
  localparam logic [3:0] OP_ALUI   = 4'h2;
  localparam logic [3:0] OP_BUBBLE = 4'h3;
  localparam logic [3:0] OP_BEQ    = 4'h4;
  localparam logic [3:0] OP_BGT    = 4'h5;
  localparam logic [3:0] OP_BLT    = 4'h6;
  localparam logic [3:0] OP_JMP    = 4'h7;
  localparam logic [3:0] OP_LD     = 4'h8;
  localparam logic [3:0] OP_ST     = 4'h9;

  // Instruction field positions
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned FUNC_MSB   = 3;
  localparam int unsigned FUNC_LSB   = 0;
  localparam int unsigned BR_OFF_W   = 8;   // branch offset: instr[7:0], in halfwords
  localparam int unsigned JMP_OFF_W  = 12;  // jump offset: instr[11:0], in halfwords

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target adder for the fetch stage.
// Computes (if_id_pc + 2) + (sign-extended offset << 1), modulo 2^PC_W.
//   if_id_pc    in  PC of the instruction currently in IF/ID
//   if_id_instr in  instruction currently in IF/ID (offset source)
//   b_jmp       in  1 = branch (8-bit offset), 0 = jump (12-bit offset)
//   target      out computed redirect target
// PC_W must exceed JMP_OFF_W for the sign extension below.
module pc_target_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16
) (
  input  logic [PC_W-1:0]    if_id_pc,
  input  logic [INSTR_W-1:0] if_id_instr,
  input  logic               b_jmp,
  output logic [PC_W-1:0]    target
);

  logic [PC_W-1:0] base;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_off;
  logic [PC_W-1:0] off;

  always_comb begin
    base    = if_id_pc + PC_W'(2);
    br_off  = {{(PC_W - BR_OFF_W){if_id_instr[BR_OFF_W-1]}}, if_id_instr[BR_OFF_W-1:0]};
    jmp_off = {{(PC_W - JMP_OFF_W){if_id_instr[JMP_OFF_W-1]}}, if_id_instr[JMP_OFF_W-1:0]};
    off     = b_jmp ? br_off : jmp_off;
    // Offsets count halfwords; the shift drops the top bit, which is harmless modulo 2^PC_W.
    target  = base + {off[PC_W-2:0], 1'b0};
  end

  // Opcode bits and the shifted-out offset MSB play no part in the target.
  logic unused_bits;
  assign unused_bits = ^{if_id_instr[INSTR_W-1:JMP_OFF_W], off[PC_W-1]};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address, registers the fetched instruction
// and applies halt / stall / redirect / flush from the control unit and hazard logic.
//   clk, reset             clock, async active-low reset
//   imem_addr / imem_rdata instruction memory (combinational ROM)
//   stall                  hold pc and IF/ID
//   if_flush               bubble into IF/ID, pc still advances
//   pc_op, b_jmp           redirect to branch (b_jmp=1) or jump target
//   halt, overflow_error_warning  stop fetching (ERROR when overflow flagged)
//   pc, if_id_*            architectural state
//   opcode, function_code  fields of if_id_instr
//   halted, error          stop status
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               if_flush,
  input  logic               pc_op,
  input  logic               b_jmp,
  input  logic               halt,
  input  logic               overflow_error_warning,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic [3:0]         opcode,
  output logic [3:0]         function_code,
  output logic               halted,
  output logic               error
);

  localparam logic [INSTR_W-1:0] Bubble = INSTR_W'(BUBBLE_INSTR);

  fetch_state_e state_q, state_d;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    target;
  logic               fetch_en;

  pc_target_calc #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_pc_target_calc (
    .if_id_pc    (if_pc_q),
    .if_id_instr (instr_q),
    .b_jmp       (b_jmp),
    .target      (target)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: HALT and ERROR are terminal until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (halt) begin
          state_d = overflow_error_warning ? StError : StHalt;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State outputs
  always_comb begin
    fetch_en = 1'b0;
    halted   = 1'b1;
    error    = 1'b0;
    case (state_q)
      StRun:   begin fetch_en = 1'b1; halted = 1'b0; end
      StError: error = 1'b1;
      default: ;
    endcase
  end

  // Datapath next state, in priority order halt > stall > redirect > flush > fetch.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if_pc_d = if_pc_q;
    valid_d = valid_q;
    if (fetch_en) begin
      if (halt) begin
        instr_d = Bubble;
        valid_d = 1'b0;
      end else if (stall) begin
        // Hold everything; the control unit re-evaluates the held instruction.
      end else if (pc_op) begin
        pc_d    = target;
        instr_d = Bubble;
        valid_d = 1'b0;
      end else if (if_flush) begin
        pc_d    = pc_q + PC_W'(2);
        instr_d = Bubble;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_q + PC_W'(2);
        instr_d = imem_rdata;
        if_pc_d = pc_q;
        valid_d = 1'b1;
      end
    end else begin
      instr_d = Bubble;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      instr_q <= Bubble;
      if_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      if_pc_q <= if_pc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc      = if_pc_q;
  assign if_id_valid   = valid_q;
  assign opcode        = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign function_code = instr_q[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_addr, imem_rdata;
  logic        stall = 0, if_flush = 0, pc_op = 0, b_jmp = 0, halt = 0, ovf = 0;
  logic [15:0] pc, if_id_instr, if_id_pc;
  logic        if_id_valid, halted, error;
  logic [3:0]  opcode, function_code;

  fetch_stage #(
    .PC_W     (16),
    .INSTR_W  (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .imem_addr              (imem_addr),
    .imem_rdata             (imem_rdata),
    .stall                  (stall),
    .if_flush               (if_flush),
    .pc_op                  (pc_op),
    .b_jmp                  (b_jmp),
    .halt                   (halt),
    .overflow_error_warning (ovf),
    .pc                     (pc),
    .if_id_instr            (if_id_instr),
    .if_id_pc               (if_id_pc),
    .if_id_valid            (if_id_valid),
    .opcode                 (opcode),
    .function_code          (function_code),
    .halted                 (halted),
    .error                  (error)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:32767];
  assign imem_rdata = mem[imem_addr[15:1]];

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = running, 1 = halted, 2 = error
  int          m_pc, m_ifpc, m_state;
  logic [15:0] m_instr;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ifpc = 0; m_state = 0; m_instr = 16'h3000; m_valid = 0;
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc", if_id_pc, m_ifpc);
    check("if_id_valid", if_id_valid, m_valid);
    check("opcode", opcode, m_instr[15:12]);
    check("function_code", function_code, m_instr[3:0]);
    check("halted", halted, m_state != 0);
    check("error", error, m_state == 2);
  endtask

  task automatic idle();
    stall = 0; if_flush = 0; pc_op = 0; b_jmp = 0; halt = 0; ovf = 0;
  endtask

  // Apply current inputs across one rising edge, advancing the model alongside.
  task automatic step();
    logic [15:0] fetched;
    int off;
    fetched = mem[m_pc / 2];
    check("imem_addr", imem_addr, m_pc);
    if (m_state == 0) begin
      if (halt) begin
        m_state = ovf ? 2 : 1;
        m_instr = 16'h3000; m_valid = 0;
      end else if (stall) begin
      end else if (pc_op) begin
        off = b_jmp ? sext(int'(m_instr[7:0]), 8) : sext(int'(m_instr[11:0]), 12);
        m_pc = (m_ifpc + 2 + 2 * off) & 32'hFFFF;
        m_instr = 16'h3000; m_valid = 0;
      end else if (if_flush) begin
        m_pc = (m_pc + 2) & 32'hFFFF;
        m_instr = 16'h3000; m_valid = 0;
      end else begin
        m_instr = fetched; m_ifpc = m_pc; m_valid = 1;
        m_pc = (m_pc + 2) & 32'hFFFF;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Called 1 time unit after a rising edge; leaves reset released between edges.
  task automatic do_reset();
    idle();
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    #1 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    check("reset_instr", if_id_instr, 16'h3000);
    #1 reset = 1'b1;

    // Plain fetch after reset
    mem[0] = 16'hF123; mem[1] = 16'h1456;
    step();
    check("fetch1_instr", if_id_instr, 16'hF123);
    check("fetch1_pc", if_id_pc, 16'h0000);
    check("fetch1_valid", if_id_valid, 1'b1);
    step();
    check("fetch2_instr", if_id_instr, 16'h1456);
    check("fetch2_pc", pc, 16'h0004);

    // Branch: if_id_pc=0x10, instr 0x61FC -> target 0x000A
    do_reset();
    mem[8] = 16'h61FC;
    for (int i = 0; i < 9; i++) step();
    check("br_setup_ifpc", if_id_pc, 16'h0010);
    pc_op = 1; b_jmp = 1;
    step();
    idle();
    check("branch_pc", pc, 16'h000A);
    check("branch_bubble", if_id_instr, 16'h3000);
    check("branch_valid", if_id_valid, 1'b0);

    // Jump: if_id_pc=0, instr 0x7800 -> target 0xF002
    do_reset();
    mem[0] = 16'h7800;
    step();
    pc_op = 1; b_jmp = 0;
    step();
    idle();
    check("jump_pc", pc, 16'hF002);

    // Stall holds a pending redirect for two edges
    mem[16'hF002 >> 1] = 16'h4003;  // branch +3 halfwords -> 0xF00A
    step();
    stall = 1; pc_op = 1; b_jmp = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc", pc, 16'hF004);
      check("stall_instr", if_id_instr, 16'h4003);
    end
    stall = 0;
    step();
    idle();
    check("stall_release_pc", pc, 16'hF00A);

    // Wrap from 0xFFFE to 0
    do_reset();
    mem[0] = 16'h7FFE;  // jump -2 halfwords -> 0xFFFE
    step();
    pc_op = 1; b_jmp = 0;
    step();
    idle();
    check("wrap_setup_pc", pc, 16'hFFFE);
    step();
    check("wrap_pc", pc, 16'h0000);
    check("wrap_ifpc", if_id_pc, 16'hFFFE);

    // Halt with overflow at pc=0x20, then ignore pc_op pulses
    do_reset();
    for (int i = 0; i < 16; i++) step();
    halt = 1; ovf = 1;
    step();
    idle();
    check("err_error", error, 1'b1);
    check("err_halted", halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      pc_op = 1'($urandom_range(0, 1));
      b_jmp = 1'($urandom_range(0, 1));
      step();
      check("err_pc_hold", pc, 16'h0020);
    end
    @(negedge clk);
    do_reset();
    check("err_reset_pc", pc, 16'h0000);
    check("err_reset_error", error, 1'b0);

    // Randomized run against the model
    for (int n = 0; n < 800; n++) begin
      if (m_state != 0 && $urandom_range(0, 7) == 0) do_reset();
      halt     = ($urandom_range(0, 63) == 0);
      ovf      = 1'($urandom_range(0, 1));
      stall    = ($urandom_range(0, 3) == 0);
      pc_op    = ($urandom_range(0, 4) == 0);
      b_jmp    = 1'($urandom_range(0, 1));
      if_flush = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
